// File: rtl/bus_arbiter16_pkg.sv
// Shared definitions for the two-port 16-bit memory arbiter: state codes,
// owner encodings and the bus word type.
package bus_arbiter16_pkg;

  localparam int unsigned BusWidth = 16;

  typedef logic [BusWidth-1:0] word_t;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic OwnerA = 1'b0;
  localparam logic OwnerB = 1'b1;

endpackage

// File: rtl/bus_arbiter16_if.sv
// Requester A/B handshakes plus the shared memory port, bundled for the arbiter.
interface bus_arbiter16_if;
  import bus_arbiter16_pkg::*;

  logic  req_a;
  logic  we_a;
  word_t addr_a;
  word_t wdata_a;
  logic  ack_a;
  word_t rdata_a;

  logic  req_b;
  logic  we_b;
  word_t addr_b;
  word_t wdata_b;
  logic  ack_b;
  word_t rdata_b;

  word_t mem_addr;
  word_t mem_wdata;
  logic  mem_we;
  word_t mem_rdata;

  logic  owner;
  logic  busy;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_rdata,
    output ack_a, rdata_a, ack_b, rdata_b,
    output mem_addr, mem_wdata, mem_we,
    output owner, busy
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_rdata,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  mem_addr, mem_wdata, mem_we,
    input  owner, busy
  );

endinterface

// File: rtl/bus_arbiter16_mux16.sv
// 2:1 word multiplexer used to pick the next grant's address and write data.
module Mux16
  import bus_arbiter16_pkg::*;
(
  input  logic  sel,
  input  word_t d0,
  input  word_t d1,
  output word_t y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/bus_arbiter16.sv
// Round-robin arbiter sharing one registered 16-bit memory port between
// requesters A and B; one word per grant, fixed LAT-cycle access.
module bus_arbiter16
  import bus_arbiter16_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input logic            clk,
  input logic            reset,
  bus_arbiter16_if.slave bus
);

  localparam logic [3:0] LatCnt = 4'(LAT);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic       mem_we_q, mem_we_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  word_t      mem_addr_q, mem_addr_d;
  word_t      mem_wdata_q, mem_wdata_d;
  word_t      rdata_a_q, rdata_a_d;
  word_t      rdata_b_q, rdata_b_d;

  logic  grant_any;
  logic  grant_sel;
  word_t next_addr;
  word_t next_wdata;

  assign grant_any = bus.req_a | bus.req_b;
  // B wins when alone, or on contention when A held the port last
  assign grant_sel = bus.req_b & (~bus.req_a | (last_q == OwnerA));

  Mux16 u_addr_mux (
    .sel (grant_sel),
    .d0  (bus.addr_a),
    .d1  (bus.addr_b),
    .y   (next_addr)
  );

  Mux16 u_wdata_mux (
    .sel (grant_sel),
    .d0  (bus.wdata_a),
    .d1  (bus.wdata_b),
    .y   (next_wdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          mem_addr_d  = next_addr;
          mem_wdata_d = next_wdata;
          mem_we_d    = grant_sel ? bus.we_b : bus.we_a;
          owner_d     = grant_sel;
          cnt_d       = LatCnt;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        // Write strobe is only asserted in the first busy cycle
        mem_we_d = 1'b0;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (owner_q == OwnerB) begin
            rdata_b_d = bus.mem_rdata;
            ack_b_d   = 1'b1;
          end else begin
            rdata_a_d = bus.mem_rdata;
            ack_a_d   = 1'b1;
          end
          last_d  = owner_q;
          state_d = StResp;
        end
      end
      StResp: begin
        mem_we_d = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      last_q      <= OwnerB;
      owner_q     <= OwnerA;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
    end
  end

  assign bus.ack_a     = ack_a_q;
  assign bus.ack_b     = ack_b_q;
  assign bus.rdata_a   = rdata_a_q;
  assign bus.rdata_b   = rdata_b_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bus_arbiter16.sv
// Scoreboard bench for bus_arbiter16: one instance at LAT=1 and one at LAT=3,
// selected by sel; expected transactions are queued at issue and retired on ack.
module tb_bus_arbiter16;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;

  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [15:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;

  logic        o_ack_a, o_ack_b, o_mem_we, o_owner, o_busy;
  logic [15:0] o_rdata_a, o_rdata_b, o_mem_addr, o_mem_wdata;

  txn_t        exp_q[$];
  logic [15:0] mdl_ra = '0, mdl_rb = '0;
  int          we_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0010) return 16'h1234;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  bus_arbiter16_if bif1 ();
  bus_arbiter16_if bif3 ();

  bus_arbiter16 #(.LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bif1));
  bus_arbiter16 #(.LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bif3));

  assign bif1.req_a     = req_a & ~sel;
  assign bif1.req_b     = req_b & ~sel;
  assign bif3.req_a     = req_a & sel;
  assign bif3.req_b     = req_b & sel;
  assign bif1.we_a      = we_a;
  assign bif1.we_b      = we_b;
  assign bif3.we_a      = we_a;
  assign bif3.we_b      = we_b;
  assign bif1.addr_a    = addr_a;
  assign bif1.addr_b    = addr_b;
  assign bif3.addr_a    = addr_a;
  assign bif3.addr_b    = addr_b;
  assign bif1.wdata_a   = wdata_a;
  assign bif1.wdata_b   = wdata_b;
  assign bif3.wdata_a   = wdata_a;
  assign bif3.wdata_b   = wdata_b;
  assign bif1.mem_rdata = mem_fn(bif1.mem_addr);
  assign bif3.mem_rdata = mem_fn(bif3.mem_addr);

  assign o_ack_a     = sel ? bif3.ack_a     : bif1.ack_a;
  assign o_ack_b     = sel ? bif3.ack_b     : bif1.ack_b;
  assign o_rdata_a   = sel ? bif3.rdata_a   : bif1.rdata_a;
  assign o_rdata_b   = sel ? bif3.rdata_b   : bif1.rdata_b;
  assign o_mem_addr  = sel ? bif3.mem_addr  : bif1.mem_addr;
  assign o_mem_wdata = sel ? bif3.mem_wdata : bif1.mem_wdata;
  assign o_mem_we    = sel ? bif3.mem_we    : bif1.mem_we;
  assign o_owner     = sel ? bif3.owner     : bif1.owner;
  assign o_busy      = sel ? bif3.busy      : bif1.busy;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic score();
    txn_t e;
    if (o_mem_we) we_cnt++;
    if (o_ack_a || o_ack_b) begin
      if (exp_q.size() == 0) begin
        check_eq("ack_unexpected", {30'd0, o_ack_b, o_ack_a}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ack_port", {30'd0, o_ack_b, o_ack_a}, e.port ? 32'd2 : 32'd1);
        check_eq("owner", {31'd0, o_owner}, {31'd0, e.port});
        check_eq("mem_addr", {16'd0, o_mem_addr}, {16'd0, e.addr});
        check_eq("mem_wdata", {16'd0, o_mem_wdata}, {16'd0, e.wdata});
        check_eq("we_pulse", we_cnt, e.we ? 32'd1 : 32'd0);
        check_eq("busy_resp", {31'd0, o_busy}, 32'd1);
        if (e.port) mdl_rb = e.rdata;
        else mdl_ra = e.rdata;
      end
      we_cnt = 0;
    end
    check_eq("rdata_a", {16'd0, o_rdata_a}, {16'd0, mdl_ra});
    check_eq("rdata_b", {16'd0, o_rdata_b}, {16'd0, mdl_rb});
  endtask

  // One cycle: advance past the rising edge, then sample and score
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      we_cnt = 0;
      mdl_ra = '0;
      mdl_rb = '0;
      exp_q.delete();
    end else begin
      score();
    end
  endtask

  task automatic issue(input logic port, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata);
    txn_t t;
    t.port  = port;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = mem_fn(addr);
    exp_q.push_back(t);
    if (port) begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
    end
  endtask

  task automatic wait_ack(input logic port, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (port ? o_ack_b : o_ack_a) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check_eq("ack_timeout", 32'd0, 32'd1);
    if (port) req_b = 1'b0;
    else req_a = 1'b0;
  endtask

  task automatic apply_reset();
    req_a = 1'b0;
    req_b = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_mem_addr", {16'd0, o_mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", {16'd0, o_mem_wdata}, 32'd0);
    check_eq("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
    check_eq("rst_acks", {30'd0, o_ack_b, o_ack_a}, 32'd0);
    check_eq("rst_rdata", {o_rdata_b, o_rdata_a}, 32'd0);
    check_eq("rst_owner", {31'd0, o_owner}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
  endtask

  // Both requests held; grants must alternate starting with A
  task automatic contend(input int total, input int lat, input logic [15:0] base);
    int          cyc;
    bit          got;
    logic        p;
    logic [15:0] a;
    issue(1'b0, 1'b0, base, 16'h0000);
    issue(1'b1, 1'b1, base + 16'h0100, 16'h5500);
    for (int n = 0; n < total; n++) begin
      got = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 40 && !got; i++) begin
        step();
        cyc = i;
        got = o_ack_a | o_ack_b;
      end
      if (!got) begin
        check_eq("contend_timeout", 32'd0, 32'd1);
        break;
      end
      check_eq("grant_order", {31'd0, o_ack_b}, n % 2);
      check_eq("grant_spacing", cyc, (n == 0) ? lat + 1 : lat + 2);
      p = o_ack_b;
      if (n < total - 2) begin
        a = (p ? base + 16'h0100 : base) + 16'(n + 1);
        issue(p, p, a, 16'h5500 + 16'(n + 1));
      end
      if (n == total - 1) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
  endtask

  initial begin
    int cyc;

    // LAT=1 instance
    sel = 1'b0;
    apply_reset();
    check_reset_vals();

    issue(1'b0, 1'b0, 16'h0010, 16'h0000);
    step();
    check_eq("rd_c1_addr", {16'd0, o_mem_addr}, 32'h0010);
    check_eq("rd_c1_busy", {31'd0, o_busy}, 32'd1);
    step();
    check_eq("rd_c2_ack", {31'd0, o_ack_a}, 32'd1);
    check_eq("rd_c2_rdata", {16'd0, o_rdata_a}, 32'h1234);
    req_a = 1'b0;
    step();
    check_eq("rd_c3_busy", {31'd0, o_busy}, 32'd0);

    issue(1'b1, 1'b1, 16'h4000, 16'hBEEF);
    step();
    check_eq("wr_c1_we", {31'd0, o_mem_we}, 32'd1);
    check_eq("wr_c1_wdata", {16'd0, o_mem_wdata}, 32'hBEEF);
    check_eq("wr_c1_owner", {31'd0, o_owner}, 32'd1);
    wait_ack(1'b1, cyc);
    check_eq("wr_latency", cyc, 32'd1);
    for (int i = 0; i < 3; i++) step();
    check_eq("wr_rdata_a_kept", {16'd0, o_rdata_a}, 32'h1234);

    contend(4, 1, 16'h0100);
    for (int i = 0; i < 3; i++) step();
    check_eq("contend1_idle", {31'd0, o_busy}, 32'd0);

    // LAT=3 instance
    sel = 1'b1;
    apply_reset();
    check_reset_vals();

    issue(1'b0, 1'b1, 16'h0040, 16'hCAFE);
    step();
    check_eq("rb_c1_busy", {31'd0, o_busy}, 32'd1);
    check_eq("rb_c1_we", {31'd0, o_mem_we}, 32'd1);
    #1 reset = 1'b1;
    req_a = 1'b0;
    #1;
    check_reset_vals();
    step();
    step();
    check_eq("rb_no_ack", {31'd0, o_ack_a}, 32'd0);
    reset = 1'b0;
    step();
    issue(1'b0, 1'b0, 16'h0010, 16'h0000);
    wait_ack(1'b0, cyc);
    check_eq("rb_regrant_lat", cyc, 32'd4);
    check_eq("rb_regrant_rdata", {16'd0, o_rdata_a}, 32'h1234);
    step();

    // After reset A must win the first contention again
    apply_reset();
    contend(2, 3, 16'h0300);
    for (int i = 0; i < 3; i++) step();

    issue(1'b0, 1'b0, 16'h0077, 16'h0000);
    step();
    step();
    req_a = 1'b0;
    step();
    check_eq("drop_c3_noack", {31'd0, o_ack_a}, 32'd0);
    step();
    check_eq("drop_c4_ack", {31'd0, o_ack_a}, 32'd1);
    step();
    check_eq("drop_c5_busy", {31'd0, o_busy}, 32'd0);
    for (int i = 0; i < 3; i++) step();

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter16.md
# bus_arbiter16

Two-port arbiter that time-shares a single 16-bit memory port between requester A (CPU data side) and requester B (DMA/peripheral master). It accepts one word transaction per grant, drives the shared address/data/write-enable registers, waits a parameterised memory latency, returns read data with a one-cycle acknowledge, and alternates priority round-robin on contention. It sits between the two masters and the RAM/memory-mapped I/O decode.

## Interface
- `LAT`, 1: memory read latency in cycles, from `mem_addr` valid to `mem_rdata` valid; legal range 1..15.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `req_a` in 1: A requests a transaction; held until `ack_a`.
- `we_a` in 1: A transaction is a write.
- `addr_a` in 16: A word address.
- `wdata_a` in 16: A write data.
- `ack_a` out 1: one-cycle completion pulse to A.
- `rdata_a` out 16: A read data, valid while `ack_a`=1, held afterwards.
- `req_b`, `we_b`, `addr_b`, `wdata_b`, `ack_b`, `rdata_b`: same as A, for B.
- `mem_addr` out 16: shared port address (registered).
- `mem_wdata` out 16: shared port write data (registered).
- `mem_we` out 1: shared port write strobe (registered).
- `mem_rdata` in 16: shared port read data.
- `owner` out 1: 0 = A, 1 = B; current or most recent grant holder (select for datapath muxes).
- `busy` out 1: high in BUSY and RESP.

## Operation
- States: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE: no requests -> stay. Exactly one request -> grant it. Both -> grant the port not equal to `last`; `last` resets to B so A wins the first contention.
- Grant (IDLE edge): latch chosen `addr`/`wdata`/`we` into `mem_*`, set `owner`, load `cnt`=LAT, go BUSY.
- BUSY: `mem_addr`/`mem_wdata` stable; `mem_we` equals latched we in the first BUSY cycle only, 0 afterwards. `cnt` decrements each cycle; at the edge where `cnt`=1, capture `mem_rdata` into owner's `rdata_x` (reads and writes both capture), set `last`=owner, go RESP.
- RESP: owner's `ack_x`=1 for this single cycle; next edge -> IDLE, `mem_we` stays 0.
- A grant is committed: dropping `req_x` during BUSY does not abort; ack still pulses.
- Requester must deassert `req_x` in the cycle after `ack_x`; a req still high in IDLE is a new transaction.
- Non-owner `rdata` is never modified.
- `owner`, `mem_addr`, `mem_wdata` hold their values in IDLE.

## Timing
- Reset values: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `ack_a`=`ack_b`=0, `rdata_a`=`rdata_b`=0, `owner`=0, `busy`=0, `cnt`=0, `last`=B.
- Request seen in IDLE at cycle 0 -> BUSY cycles 1..LAT -> ack in cycle LAT+1 -> IDLE at LAT+2. Back-to-back throughput: one word per LAT+2 cycles.
- Contention with both reqs held: grants alternate A, B, A, B…
- Reset asserted mid-BUSY/RESP: immediate return to reset values, no ack, `last`=B.
- `cnt` is 4 bits; LAT=1 gives exactly one BUSY cycle.

## Structure
- Shared package: state encodings (IDLE/BUSY/RESP), OWNER_A=0/OWNER_B=1, bus width 16.
- Next-grant address and write-data selection uses two `Mux16` instances with `sel` = next owner, feeding the `mem_*` registers; no other sub-module.

## Test plan
- Reset mid-BUSY (A write in flight) -> all outputs 0 immediately, no `ack_a`, next A request granted normally.
- LAT=1, A read of 0x0010, mem returns 0x1234 -> `mem_addr`=0x0010 cycle 1, `ack_a`=1 with `rdata_a`=0x1234 cycle 2, `busy`=0 cycle 3.
- B write 0xBEEF to 0x4000 -> `mem_we`=1 exactly one cycle, `owner`=1, `ack_b` once, `rdata_a` unchanged.
- Both reqs held for 4 transactions -> grant order A, B, A, B; `owner` toggles 0,1,0,1.
- LAT=3, A drops `req_a` in second BUSY cycle -> `ack_a` still at cycle 4, `busy` low cycle 5.
